// File: rtl/serial_pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_pkg
// Shared types and helpers for the serial pattern transmitter.
//   tx_state_e : FSM state encoding (IDLE, SHIFT, GAP)
//   clamp_len  : limits a requested bit count to the pattern width
// -----------------------------------------------------------------------------
package serial_pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_e;

   // Requests longer than the register are treated as a full-width pattern.
   function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                             input logic [31:0] max_len);
      logic [31:0] res;
      if (len > max_len) begin
         res = max_len;
      end else begin
         res = len;
      end
      return res;
   endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// serial_pattern_if
// Load handshake and serial output bundle of serial_pattern_tx.
//   load_valid/load_ready : pattern request handshake
//   load_data/load_len    : pattern word and bit count (sampled on transfer)
//   dout/dout_valid       : serial bit stream, MSB of the pattern first
//   busy/done             : activity flag and end-of-pattern pulse
// master = pattern source, slave = transmitter.
// -----------------------------------------------------------------------------
interface serial_pattern_if #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [LW-1:0]    load_len;
   logic             dout;
   logic             dout_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data, load_len,
      input  load_ready, dout, dout_valid, busy, done
   );

   modport slave (
      input  load_valid, load_data, load_len,
      output load_ready, dout, dout_valid, busy, done
   );
endinterface

// File: rtl/serial_pattern_tx_shift_reg.sv
// -----------------------------------------------------------------------------
// tx_shift_reg
// Left-shift register with parallel load plus a remaining-bit down-counter.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   load         : capture load_data[load_len-1:0] left-aligned, count = load_len
//   shift        : shift left by one, count down (saturates at zero)
//   first_bit    : MSB the register would hold if loaded this cycle
//   next_bit     : MSB the register will hold after the next shift
//   bit_cnt      : bits still to be sent, including the one on the line
// -----------------------------------------------------------------------------
module tx_shift_reg #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LW-1:0]    load_len,
   output logic             first_bit,
   output logic             next_bit,
   output logic [LW-1:0]    bit_cnt
);

   logic [WIDTH-1:0] sreg_r;
   logic [LW-1:0]    cnt_r;
   logic [WIDTH-1:0] aligned_s;
   logic [WIDTH-1:0] shifted_s;
   logic [LW-1:0]    lsh_s;

   // Left-align the requested bits so bit load_len-1 lands on the MSB;
   // a zero length shifts everything out and loads all zeros.
   always_comb begin
      lsh_s     = LW'(WIDTH) - load_len;
      aligned_s = load_data << lsh_s;
      shifted_s = sreg_r << 1'b1;
   end

   // Shift register and remaining-bit counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sreg_r <= {WIDTH{1'b0}};
         cnt_r  <= {LW{1'b0}};
      end else if (load) begin
         sreg_r <= aligned_s;
         cnt_r  <= load_len;
      end else if (shift) begin
         sreg_r <= shifted_s;
         cnt_r  <= (cnt_r != {LW{1'b0}}) ? (cnt_r - LW'(1)) : cnt_r;
      end else begin
         sreg_r <= sreg_r;
         cnt_r  <= cnt_r;
      end
   end

   assign first_bit = aligned_s[WIDTH-1];
   assign next_bit  = shifted_s[WIDTH-1];
   assign bit_cnt   = cnt_r;

endmodule

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
// Parallel-to-serial pattern transmitter. A word and bit count accepted over
// the load handshake are sent MSB-first, one bit per clock, followed by
// IDLE_GAP low idle cycles. done pulses once per accepted pattern.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   sp    : serial_pattern_if slave (handshake, serial output, status)
// All outputs except load_ready are registered; load_ready is only high in
// IDLE while reset is released.
// -----------------------------------------------------------------------------
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int IDLE_GAP = 1
) (
   input  logic            clock,
   input  logic            reset,
   serial_pattern_if.slave sp
);

   localparam int LW = $clog2(WIDTH + 1);
   // Gap counter holds IDLE_GAP-1 down to 0.
   localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (IDLE_GAP > 0) ? GW'(IDLE_GAP - 1) : {GW{1'b0}};

   tx_state_e     state_r;
   tx_state_e     state_nxt_s;
   logic [GW-1:0] gap_cnt_r;
   logic [GW-1:0] gap_nxt_s;
   logic          dout_r;
   logic          dout_nxt_s;
   logic          dv_r;
   logic          dv_nxt_s;
   logic          busy_r;
   logic          busy_nxt_s;
   logic          done_r;
   logic          done_nxt_s;

   logic          load_ready_s;
   logic          xfer_s;
   logic          load_s;
   logic          shift_s;
   logic [LW-1:0] len_c_s;
   logic          first_bit_s;
   logic          next_bit_s;
   logic [LW-1:0] bit_cnt_s;

   assign load_ready_s = (state_r == ST_IDLE) & reset;
   assign xfer_s       = sp.load_valid & load_ready_s;
   assign len_c_s      = LW'(clamp_len(32'(sp.load_len), 32'(WIDTH)));

   tx_shift_reg #(
      .WIDTH (WIDTH),
      .LW    (LW)
   ) u_shift (
      .clock     (clock),
      .reset     (reset),
      .load      (load_s),
      .shift     (shift_s),
      .load_data (sp.load_data),
      .load_len  (len_c_s),
      .first_bit (first_bit_s),
      .next_bit  (next_bit_s),
      .bit_cnt   (bit_cnt_s)
   );

   // Next-state and next-output logic. Outputs are computed one cycle ahead so
   // the registered dout shows the first bit the cycle after the transfer.
   always_comb begin
      state_nxt_s = state_r;
      gap_nxt_s   = gap_cnt_r;
      dout_nxt_s  = 1'b0;
      dv_nxt_s    = 1'b0;
      done_nxt_s  = 1'b0;
      load_s      = 1'b0;
      shift_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) begin
               load_s = 1'b1;
               if (len_c_s != {LW{1'b0}}) begin
                  state_nxt_s = ST_SHIFT;
                  dout_nxt_s  = first_bit_s;
                  dv_nxt_s    = 1'b1;
               end else begin
                  // Empty pattern: nothing on the line, only the done pulse.
                  done_nxt_s = 1'b1;
                  if (IDLE_GAP > 0) begin
                     state_nxt_s = ST_GAP;
                     gap_nxt_s   = GAP_LOAD;
                  end else begin
                     state_nxt_s = ST_IDLE;
                  end
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_s = 1'b1;
            // bit_cnt counts the bit currently on dout; more than one left
            // means another bit follows.
            if (bit_cnt_s > LW'(1)) begin
               dout_nxt_s = next_bit_s;
               dv_nxt_s   = 1'b1;
            end else begin
               done_nxt_s = 1'b1;
               if (IDLE_GAP > 0) begin
                  state_nxt_s = ST_GAP;
                  gap_nxt_s   = GAP_LOAD;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == {GW{1'b0}}) begin
               state_nxt_s = ST_IDLE;
            end else begin
               gap_nxt_s = gap_cnt_r - GW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            gap_nxt_s   = {GW{1'b0}};
         end
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // State, gap counter and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         gap_cnt_r <= {GW{1'b0}};
         dout_r    <= 1'b0;
         dv_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         gap_cnt_r <= gap_nxt_s;
         dout_r    <= dout_nxt_s;
         dv_r      <= dv_nxt_s;
         busy_r    <= busy_nxt_s;
         done_r    <= done_nxt_s;
      end
   end

   assign sp.load_ready = load_ready_s;
   assign sp.dout       = dout_r;
   assign sp.dout_valid = dv_r;
   assign sp.busy       = busy_r;
   assign sp.done       = done_r;

endmodule
